// File: rtl/ovl_fire_pkg.sv
// rtl/ovl_fire_pkg.sv - shared fire-bus constants and event record type
//
// Purpose: bit positions inside one checker's fire slice and the event record
// carried through the collector queue. The record id is sized for the largest
// supported checker bank (32). The top truncates it to ID_WIDTH on output.
// Optional feature macro used by the bundle: OVL_FIRE_COVER_EN.
package ovl_fire_pkg;

  localparam int FIRE_2STATE  = 0;
  localparam int FIRE_XCHECK  = 1;
  localparam int FIRE_COVER   = 2;
  localparam int FIRE_WIDTH   = 3;
  localparam int ID_MAX_WIDTH = 5;

  typedef struct packed {
    logic [ID_MAX_WIDTH-1:0] id;
    logic [FIRE_WIDTH-1:0]   bits;
    logic                    merged;
  } ovl_fire_evt_t;

endpackage

// File: rtl/ovl_fire_fifo.sv
// rtl/ovl_fire_fifo.sv - synchronous event FIFO with registered head output
//
// Purpose: stores up to DEPTH event records. The head record and valid flag
// are registered, so a push into an empty queue is visible right after that
// edge. The caller must not push when full unless it also pops.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   flush               - synchronous empty; wins over push/pop
//   push, din           - enqueue request and record
//   pop                 - dequeue head (ignored when empty)
//   full, empty         - occupancy flags
//   dout, valid         - registered head record and its valid flag
module ovl_fire_fifo
  import ovl_fire_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  ovl_fire_evt_t din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output ovl_fire_evt_t dout,
  output logic          valid
);

  localparam int AW = $clog2(DEPTH);

  ovl_fire_evt_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   count, count_next;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign rd_next = rd_ptr + AW'(do_pop);
  assign count_next = count + (AW+1)'(push) - (AW+1)'(do_pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      valid  <= (count_next != '0);
      // New head comes straight from din when the write lands on it.
      dout   <= (push && (wr_ptr == rd_next)) ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/ovl_fire_collector.sv
// rtl/ovl_fire_collector.sv - collects OVL checker fire buses into an event queue
//
// Purpose: samples NUM_CHECKERS 3-bit fire slices into per-checker pending
// records, arbitrates lowest index first into ovl_fire_fifo, and keeps sticky
// violation flags plus saturating violation/cover counters.
// Macro: OVL_FIRE_COVER_EN enables cover events and cover_count.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   enable              - gate for fire_in sampling
//   fire_in             - {cover, xcheck, 2state} per checker, checker k at [3k+2:3k]
//   clear               - synchronous flush of queue, pending, sticky, counters
//   evt_valid/evt_ready - event handshake
//   evt_id, evt_bits, evt_merged - head event record
//   sticky_viol         - per-checker sticky violation flag
//   viol_count, cover_count - saturating sample counters
module ovl_fire_collector
  import ovl_fire_pkg::*;
#(
  parameter int NUM_CHECKERS = 4,
  parameter int ID_WIDTH     = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_CHECKERS*3-1:0]    fire_in,
  input  logic                         clear,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [ID_WIDTH-1:0]          evt_id,
  output logic [2:0]                   evt_bits,
  output logic                         evt_merged,
  output logic [NUM_CHECKERS-1:0]      sticky_viol,
  output logic [CNT_WIDTH-1:0]         viol_count,
  output logic [CNT_WIDTH-1:0]         cover_count
);

`ifdef OVL_FIRE_COVER_EN
  localparam logic [FIRE_WIDTH-1:0] FIRE_MASK = 3'b111;
`else
  localparam logic [FIRE_WIDTH-1:0] FIRE_MASK = 3'b011;
`endif

  logic [FIRE_WIDTH-1:0]   fire_s    [NUM_CHECKERS];
  logic [FIRE_WIDTH-1:0]   pend_bits [NUM_CHECKERS];
  logic [NUM_CHECKERS-1:0] pend, pend_merged, sticky_set;
  logic [6:0]              viol_inc, cover_inc;
  logic [ID_MAX_WIDTH-1:0] sel;
  logic [FIRE_WIDTH-1:0]   sel_bits;
  logic                    sel_merged, any_pend, push, pop, fifo_full, fifo_empty;
  ovl_fire_evt_t           push_evt, head;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [6:0] b);
    logic [CNT_WIDTH+6:0] s;
    s = {7'd0, a} + {{CNT_WIDTH{1'b0}}, b};
    return (|s[CNT_WIDTH+6:CNT_WIDTH]) ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  // Masked sample of every slice; clear discards the same-cycle fire.
  always_comb begin
    viol_inc   = '0;
    cover_inc  = '0;
    sticky_set = '0;
    for (int k = 0; k < NUM_CHECKERS; k++) begin
      fire_s[k] = (enable && !clear) ? (fire_in[k*FIRE_WIDTH +: FIRE_WIDTH] & FIRE_MASK) : '0;
      if (fire_s[k][FIRE_2STATE] || fire_s[k][FIRE_XCHECK]) begin
        viol_inc      = viol_inc + 7'd1;
        sticky_set[k] = 1'b1;
      end
      if (fire_s[k][FIRE_COVER]) cover_inc = cover_inc + 7'd1;
    end
  end

  // Lowest-index pending entry wins; descending loop leaves the lowest last.
  always_comb begin
    any_pend   = 1'b0;
    sel        = '0;
    sel_bits   = '0;
    sel_merged = 1'b0;
    for (int k = NUM_CHECKERS - 1; k >= 0; k--) begin
      if (pend[k]) begin
        any_pend   = 1'b1;
        sel        = ID_MAX_WIDTH'(k);
        sel_bits   = pend_bits[k];
        sel_merged = pend_merged[k];
      end
    end
  end

  assign pop      = evt_valid && evt_ready;
  assign push     = any_pend && (!fifo_full || pop) && !clear;
  assign push_evt = '{id: sel, bits: sel_bits, merged: sel_merged};

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pend        <= '0;
      pend_merged <= '0;
      sticky_viol <= '0;
      viol_count  <= '0;
      for (int k = 0; k < NUM_CHECKERS; k++) pend_bits[k] <= '0;
    end else begin
      sticky_viol <= sticky_viol | sticky_set;
      viol_count  <= sat_add(viol_count, viol_inc);
      for (int k = 0; k < NUM_CHECKERS; k++) begin
        if (push && (sel == ID_MAX_WIDTH'(k))) begin
          // Dequeued this cycle: re-arm with only the fresh bits.
          pend[k]        <= |fire_s[k];
          pend_bits[k]   <= fire_s[k];
          pend_merged[k] <= 1'b0;
        end else if (|fire_s[k]) begin
          pend[k]        <= 1'b1;
          pend_bits[k]   <= pend_bits[k] | fire_s[k];
          pend_merged[k] <= pend_merged[k] | pend[k];
        end
      end
    end
  end

`ifdef OVL_FIRE_COVER_EN
  always_ff @(posedge clock) begin
    if (reset || clear) cover_count <= '0;
    else                cover_count <= sat_add(cover_count, cover_inc);
  end
`else
  assign cover_count = '0;
`endif

  ovl_fire_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (clear),
    .push  (push),
    .din   (push_evt),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (head),
    .valid (evt_valid)
  );

  assign evt_id     = ID_WIDTH'(head.id);
  assign evt_bits   = head.bits;
  assign evt_merged = head.merged;

  logic unused_ok;
  assign unused_ok = ^{head.id, cover_inc, fifo_empty};

endmodule

// File: tb/tb_ovl_fire_collector.sv
// tb/tb_ovl_fire_collector.sv - directed self-checking bench for ovl_fire_collector
module tb_ovl_fire_collector;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [11:0] fire_in = '0;
  logic        clear = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [1:0]  evt_id;
  logic [2:0]  evt_bits;
  logic        evt_merged;
  logic [3:0]  sticky_viol;
  logic [15:0] viol_count;
  logic [15:0] cover_count;

  int vectors = 0;
  int miscompares = 0;

  ovl_fire_collector #(
    .NUM_CHECKERS(4), .ID_WIDTH(2), .FIFO_DEPTH(8), .CNT_WIDTH(16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .fire_in     (fire_in),
    .clear       (clear),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_bits    (evt_bits),
    .evt_merged  (evt_merged),
    .sticky_viol (sticky_viol),
    .viol_count  (viol_count),
    .cover_count (cover_count)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_all();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", evt_valid); end
    vectors++; if (evt_id !== 2'd0) begin miscompares++; $display("FAIL reset_id: got %0d expected 0", evt_id); end
    vectors++; if (evt_bits !== 3'b000) begin miscompares++; $display("FAIL reset_bits: got %b expected 000", evt_bits); end
    vectors++; if (evt_merged !== 1'b0) begin miscompares++; $display("FAIL reset_merged: got %0b expected 0", evt_merged); end
    vectors++; if (sticky_viol !== 4'b0000) begin miscompares++; $display("FAIL reset_sticky: got %b expected 0000", sticky_viol); end
    vectors++; if (viol_count !== 16'd0) begin miscompares++; $display("FAIL reset_viol: got %0d expected 0", viol_count); end
    vectors++; if (cover_count !== 16'd0) begin miscompares++; $display("FAIL reset_cover: got %0d expected 0", cover_count); end
  endtask

  task automatic test_single();
    clear_all();
    evt_ready = 1'b1;
    fire_in = 12'h040;
    step();
    fire_in = '0;
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL single_t1_valid: got %0b expected 0", evt_valid); end
    vectors++; if (viol_count !== 16'd1) begin miscompares++; $display("FAIL single_viol: got %0d expected 1", viol_count); end
    vectors++; if (sticky_viol !== 4'b0100) begin miscompares++; $display("FAIL single_sticky: got %b expected 0100", sticky_viol); end
    step();
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %0b expected 1", evt_valid); end
    vectors++; if (evt_id !== 2'd2) begin miscompares++; $display("FAIL single_id: got %0d expected 2", evt_id); end
    vectors++; if (evt_bits !== 3'b001) begin miscompares++; $display("FAIL single_bits: got %b expected 001", evt_bits); end
    vectors++; if (evt_merged !== 1'b0) begin miscompares++; $display("FAIL single_merged: got %0b expected 0", evt_merged); end
    step();
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL single_drained: got %0b expected 0", evt_valid); end
  endtask

  task automatic test_multi();
    logic [1:0] exp_ids [3];
    exp_ids = '{2'd0, 2'd1, 2'd3};
    clear_all();
    evt_ready = 1'b1;
    fire_in = 12'h412;
    step();
    fire_in = '0;
    vectors++; if (viol_count !== 16'd3) begin miscompares++; $display("FAIL multi_viol: got %0d expected 3", viol_count); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (evt_valid !== 1'b1 || evt_id !== exp_ids[i] || evt_bits !== 3'b010)
        begin miscompares++; $display("FAIL multi_rec%0d: got v=%0b id=%0d bits=%b expected v=1 id=%0d bits=010", i, evt_valid, evt_id, evt_bits, exp_ids[i]); end
    end
    step();
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL multi_drained: got %0b expected 0", evt_valid); end
  endtask

  task automatic test_full();
    int nrec = 0;
    int nplain = 0;
    logic last_merged = 1'b0;
    logic bad_id = 1'b0;
    clear_all();
    evt_ready = 1'b0;
    fire_in = 12'h008;
    repeat (10) step();
    fire_in = '0;
    step();
    step();
    vectors++; if (viol_count !== 16'd10) begin miscompares++; $display("FAIL full_viol: got %0d expected 10", viol_count); end
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL full_valid: got %0b expected 1", evt_valid); end
    evt_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (evt_valid) begin
        nrec++;
        last_merged = evt_merged;
        if (!evt_merged) nplain++;
        if (evt_id !== 2'd1) bad_id = 1'b1;
      end
      step();
    end
    vectors++; if (nrec != 9) begin miscompares++; $display("FAIL full_records: got %0d expected 9", nrec); end
    vectors++; if (nplain != 8) begin miscompares++; $display("FAIL full_unmerged: got %0d expected 8", nplain); end
    vectors++; if (last_merged !== 1'b1) begin miscompares++; $display("FAIL full_last_merged: got %0b expected 1", last_merged); end
    vectors++; if (bad_id !== 1'b0) begin miscompares++; $display("FAIL full_ids: got wrong id flag %0b expected 0", bad_id); end
  endtask

  task automatic test_saturate();
    clear_all();
    evt_ready = 1'b1;
    fire_in = 12'h249;
    repeat (16383) step();
    vectors++; if (viol_count !== 16'd65532) begin miscompares++; $display("FAIL sat_below: got %0d expected 65532", viol_count); end
    vectors++; if (sticky_viol !== 4'b1111) begin miscompares++; $display("FAIL sat_sticky: got %b expected 1111", sticky_viol); end
    step();
    vectors++; if (viol_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_clamp: got %0h expected ffff", viol_count); end
    step();
    fire_in = '0;
    vectors++; if (viol_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %0h expected ffff", viol_count); end
  endtask

  task automatic test_clear();
    clear_all();
    evt_ready = 1'b0;
    fire_in = 12'h001;
    repeat (5) step();
    fire_in = '0;
    step();
    vectors++; if (evt_valid !== 1'b1 || viol_count !== 16'd5) begin miscompares++; $display("FAIL clear_pre: got v=%0b cnt=%0d expected v=1 cnt=5", evt_valid, viol_count); end
    clear = 1'b1;
    fire_in = 12'h040;
    step();
    clear = 1'b0;
    fire_in = '0;
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL clear_valid: got %0b expected 0", evt_valid); end
    vectors++; if (viol_count !== 16'd0 || cover_count !== 16'd0) begin miscompares++; $display("FAIL clear_counts: got viol=%0d cover=%0d expected 0 0", viol_count, cover_count); end
    vectors++; if (sticky_viol !== 4'b0000) begin miscompares++; $display("FAIL clear_sticky: got %b expected 0000", sticky_viol); end
    evt_ready = 1'b1;
    step();
    step();
    vectors++; if (evt_valid !== 1'b0 || sticky_viol !== 4'b0000) begin miscompares++; $display("FAIL clear_no_event: got v=%0b sticky=%b expected 0 0000", evt_valid, sticky_viol); end
  endtask

  task automatic test_enable();
    clear_all();
    enable = 1'b0;
    fire_in = 12'h249;
    step();
    fire_in = '0;
    enable = 1'b1;
    step();
    step();
    vectors++; if (evt_valid !== 1'b0 || viol_count !== 16'd0 || sticky_viol !== 4'b0000)
      begin miscompares++; $display("FAIL enable_off: got v=%0b cnt=%0d sticky=%b expected 0 0 0000", evt_valid, viol_count, sticky_viol); end
  endtask

  task automatic test_cover();
    clear_all();
    evt_ready = 1'b0;
    fire_in = 12'h004;
    step();
    fire_in = '0;
    step();
`ifdef OVL_FIRE_COVER_EN
    vectors++; if (evt_valid !== 1'b1 || evt_bits !== 3'b100) begin miscompares++; $display("FAIL cover_event: got v=%0b bits=%b expected 1 100", evt_valid, evt_bits); end
    vectors++; if (cover_count !== 16'd1) begin miscompares++; $display("FAIL cover_count: got %0d expected 1", cover_count); end
`else
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL cover_masked: got %0b expected 0", evt_valid); end
    vectors++; if (cover_count !== 16'd0) begin miscompares++; $display("FAIL cover_count: got %0d expected 0", cover_count); end
`endif
    vectors++; if (viol_count !== 16'd0 || sticky_viol !== 4'b0000) begin miscompares++; $display("FAIL cover_no_viol: got cnt=%0d sticky=%b expected 0 0000", viol_count, sticky_viol); end
    evt_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    clear_all();
    evt_ready = 1'b0;
    fire_in = 12'h249;
    step();
    fire_in = '0;
    step();
    step();
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre: got %0b expected 1", evt_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++; if (evt_valid !== 1'b0 || viol_count !== 16'd0 || sticky_viol !== 4'b0000)
      begin miscompares++; $display("FAIL rstmid_post: got v=%0b cnt=%0d sticky=%b expected 0 0 0000", evt_valid, viol_count, sticky_viol); end
    evt_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_full();
    test_clear();
    test_enable();
    test_cover();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ovl_fire_collector.md
# ovl_fire_collector

Aggregates the 3-bit `fire` vectors of up to `NUM_CHECKERS` OVL checkers into one queue of event records drained through a valid/ready handshake. It also keeps per-checker sticky status and a saturating violation counter. It sits at the sink end of the checker fire buses, between a bank of `ovl_*` checkers and a monitor, logger or register interface. It is the consumer the checkers' `fire` outputs are built for.

## Interface
- `NUM_CHECKERS`, 4: number of checker fire buses; range 1..32.
- `ID_WIDTH`, 2: width of the event checker index; must satisfy 2**ID_WIDTH >= NUM_CHECKERS.
- `FIFO_DEPTH`, 8: event queue depth; power of two, minimum 2.
- `CNT_WIDTH`, 16: width of the violation and cover counters.

Ports:
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when low, `fire_in` is ignored; queued events still drain.
- `fire_in` in NUM_CHECKERS*3: checker k occupies bits [3k+2:3k], ordered {cover, xcheck, 2state}.
- `clear` in 1: synchronous flush of queue, pending, sticky and counters.
- `evt_valid` out 1: event record available.
- `evt_ready` in 1: consumer accepts the record.
- `evt_id` out ID_WIDTH: checker index of the record.
- `evt_bits` out 3: merged fire bits {cover, xcheck, 2state}.
- `evt_merged` out 1: more than one firing was folded into this record.
- `sticky_viol` out NUM_CHECKERS: bit k is set once checker k asserts 2state or xcheck.
- `viol_count` out CNT_WIDTH: saturating count of checker-violation samples.
- `cover_count` out CNT_WIDTH: saturating count of cover samples.

## Operation
- Sampling: with `enable` high, each checker k with a nonzero fire slice ORs its bits into `pend_bits[k]` and sets `pend[k]`.
  - If `pend[k]` is already set and not being dequeued this cycle, `pend_merged[k]` is set.
- Arbiter: each cycle it selects the lowest-index set `pend[k]` and pushes {k, bits, merged} into the FIFO, then clears that pending entry.
  - A push happens only when the FIFO is not full or a pop occurs in the same cycle.
  - At most one push per cycle.
  - A fire for k in the same cycle that k is dequeued re-arms `pend[k]` with only the new bits and does not set merged.
- Full FIFO: the arbiter stalls and pending entries keep merging. No event is ever dropped; loss is reported only through `evt_merged`.
- Handshake: `evt_id`, `evt_bits` and `evt_merged` stay stable while `evt_valid` is high and `evt_ready` is low. A pop happens when valid and ready are both high.
- Counters: `viol_count` adds the popcount over k of (2state|xcheck) for the sampled cycle. `cover_count` does the same for cover. Both saturate at all-ones and never wrap.
- `sticky_viol` is set from sampled bits and cleared only by `clear` or `reset`.
- `clear` and a fire in the same cycle: clear wins and that cycle's fire is discarded. A pop in a clear cycle is ignored.
- `reset` and `clear` are equivalent except that `reset` overrides everything.

## Timing
- Reset values: `evt_valid`=0, `evt_id`=0, `evt_bits`=0, `evt_merged`=0, `sticky_viol`=0, `viol_count`=0, `cover_count`=0.
- Fire sampled at edge t sets pending. The arbiter pushes at edge t+1, and `evt_valid` is high in the cycle after edge t+1. Latency is therefore 2 cycles into an empty queue.
- Counters and sticky bits update at edge t, one cycle of latency.
- FIFO output is registered. Throughput is one event per cycle with `evt_ready` held high.
- Reset mid-operation empties the queue on the next edge, regardless of `evt_ready`.

## Configuration
- `OVL_FIRE_COVER_EN` defined: the cover bit creates events and increments `cover_count`.
- Not defined: cover bits are masked at the input and `cover_count` is tied to 0. `evt_bits[2]` is always 0, and a slice whose only bit set is cover creates no event.

## Structure
- Package `ovl_fire_pkg`:
  - bit-position constants `FIRE_2STATE`=0, `FIRE_XCHECK`=1, `FIRE_COVER`=2, and `FIRE_WIDTH`=3;
  - typedef `ovl_fire_evt_t` {id, bits, merged}.
- Sub-module `ovl_fire_fifo`: synchronous FIFO of `ovl_fire_evt_t` with full/empty flags and registered output.
- Pending registers, arbiter and counters live in `ovl_fire_collector`.

## Test plan
- Checker 2 fires 3'b001 for one cycle, `evt_ready`=1 -> `evt_valid` one cycle at t+2, `evt_id`=2, `evt_bits`=001, `evt_merged`=0; `viol_count`=1; `sticky_viol`=4'b0100.
- Checkers 0, 1 and 3 fire 3'b010 in the same cycle -> records with ids 0, 1, 3 on consecutive cycles; `viol_count`=3.
- `evt_ready`=0 and checker 1 fires 3'b001 on 10 consecutive cycles with FIFO_DEPTH=8 -> FIFO fills, no drop, final record for id 1 has `evt_merged`=1; `viol_count`=10.
- Force `viol_count` near saturation, then fire 4 checkers -> count holds at 16'hFFFF.
- Assert `clear` with 5 queued events and a fire in the same cycle -> next cycle `evt_valid`=0, counters 0, sticky 0, no event from the concurrent fire.
- Checker 0 fires 3'b100 -> with `OVL_FIRE_COVER_EN`: event bits 100 and `cover_count`=1; without it: no event and `cover_count`=0.
